// File: rtl/ram_bist_pkg.sv
// Shared types and March C- table for the RAM BIST engine.
// Elements: E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1), E4 down(r1,w0), E5 up(r0).
package ram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit 1 selects write, bit 0 selects the "1" pattern (~BG).
    typedef enum logic [1:0] {
        OP_R0 = 2'b00,
        OP_R1 = 2'b01,
        OP_W0 = 2'b10,
        OP_W1 = 2'b11
    } op_t;

    localparam int          N_ELEM    = 6;
    localparam logic [2:0]  LAST_ELEM = 3'(N_ELEM - 1);

    // Bit e describes element e.
    localparam logic [N_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
    localparam logic [N_ELEM-1:0] ELEM_DOWN    = 6'b011000;

    function automatic op_t march_op(input logic [2:0] elem, input logic op_idx);
        op_t op;
        case (elem)
            3'd0:    op = OP_W0;
            3'd1:    op = op_idx ? OP_W1 : OP_R0;
            3'd2:    op = op_idx ? OP_W0 : OP_R1;
            3'd3:    op = op_idx ? OP_W1 : OP_R0;
            3'd4:    op = op_idx ? OP_W0 : OP_R1;
            default: op = OP_R0;
        endcase
        return op;
    endfunction

    function automatic logic op_is_write(input op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_one(input op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Memory request/response bus between the BIST engine (master) and the RAM (slave).
interface ram_bist_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    modport master (
        output mem_en, mem_rw, mem_address, mem_in,
        input  mem_out
    );

    modport slave (
        input  mem_en, mem_rw, mem_address, mem_in,
        output mem_out
    );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march; the direction is latched on load so
// the terminal flag always refers to the element currently being walked.
module ram_bist_addr_gen #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              dir,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              terminal
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;

    // Next address: load to the start of the walk, or step one word; wraps freely.
    always_comb begin
        addr_d = addr_q;
        dir_d  = dir_q;
        if (load) begin
            dir_d  = dir;
            addr_d = dir ? '1 : '0;
        end else if (step) begin
            addr_d = dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end
    end

    // Address and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            dir_q  <= dir_d;
        end
    end

    assign addr     = addr_q;
    assign terminal = dir_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/ram_bist.sv
// March C- built-in self-test initiator for a single-port word RAM.
// Optional macro RAM_BIST_FAIL_COUNT_EN adds a saturating fail_count output.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = 14,
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
`ifdef RAM_BIST_FAIL_COUNT_EN
    output logic [15:0]       fail_count,
`endif
    ram_bist_if.master        bus
);
    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_idx_q, op_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] mem_in_q, mem_in_d;
    logic [DATA_W-1:0] exp_q, exp_d;
`ifdef RAM_BIST_FAIL_COUNT_EN
    logic [15:0]       fail_cnt_q, fail_cnt_d;
`endif

    logic              ag_load, ag_dir, ag_step, ag_term;
    logic [ADDR_W-1:0] ag_addr;
    logic              mismatch, last_op, issue;
    logic [2:0]        nxt_elem;
    logic              nxt_idx;
    op_t               nxt_op;
    logic [DATA_W-1:0] nxt_data;

    ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ag_load),
        .dir      (ag_dir),
        .step     (ag_step),
        .addr     (ag_addr),
        .terminal (ag_term)
    );

    // Sequencing: finish the op on the bus this cycle, pick the next op and register it.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
`ifdef RAM_BIST_FAIL_COUNT_EN
        fail_cnt_d  = fail_cnt_q;
`endif
        ag_load     = 1'b0;
        ag_dir      = 1'b0;
        ag_step     = 1'b0;
        issue       = 1'b0;
        nxt_elem    = elem_q;
        nxt_idx     = op_idx_q;
        mismatch    = (state_q == ST_RUN) && !mem_rw_q && (bus.mem_out != exp_q);
        last_op     = !ELEM_TWO_OPS[elem_q] || op_idx_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
`ifdef RAM_BIST_FAIL_COUNT_EN
                    fail_cnt_d  = '0;
`endif
                    nxt_elem    = '0;
                    nxt_idx     = 1'b0;
                    ag_load     = 1'b1;
                    ag_dir      = ELEM_DOWN[0];
                    issue       = 1'b1;
                end
            end
            ST_RUN: begin
                if (mismatch) begin
                    fail_d = 1'b1;
                    if (!fail_q) begin
                        fail_addr_d = ag_addr;
                        fail_data_d = bus.mem_out;
                    end
`ifdef RAM_BIST_FAIL_COUNT_EN
                    if (fail_cnt_q != 16'hFFFF) begin
                        fail_cnt_d = fail_cnt_q + 16'd1;
                    end
`endif
                end
                if (!last_op) begin
                    nxt_idx = 1'b1;
                    issue   = 1'b1;
                end else if (!ag_term) begin
                    nxt_idx = 1'b0;
                    ag_step = 1'b1;
                    issue   = 1'b1;
                end else if (elem_q == LAST_ELEM) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ag_load = 1'b1;
                    ag_dir  = 1'b0;
                end else begin
                    nxt_elem = elem_q + 3'd1;
                    nxt_idx  = 1'b0;
                    ag_load  = 1'b1;
                    ag_dir   = ELEM_DOWN[nxt_elem];
                    issue    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        nxt_op   = march_op(nxt_elem, nxt_idx);
        nxt_data = op_is_one(nxt_op) ? ~BG : BG;
        elem_d   = nxt_elem;
        op_idx_d = nxt_idx;
        if (issue) begin
            mem_en_d = 1'b1;
            mem_rw_d = op_is_write(nxt_op);
            mem_in_d = op_is_write(nxt_op) ? nxt_data : '0;
            exp_d    = nxt_data;
        end else begin
            mem_en_d = 1'b0;
            mem_rw_d = 1'b0;
            mem_in_d = '0;
            exp_d    = '0;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            op_idx_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_in_q    <= '0;
            exp_q       <= '0;
`ifdef RAM_BIST_FAIL_COUNT_EN
            fail_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_idx_q    <= op_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_in_q    <= mem_in_d;
            exp_q       <= exp_d;
`ifdef RAM_BIST_FAIL_COUNT_EN
            fail_cnt_q  <= fail_cnt_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign fail            = fail_q;
    assign fail_addr       = fail_addr_q;
    assign fail_data       = fail_data_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_rw      = mem_rw_q;
    assign bus.mem_address = ag_addr;
    assign bus.mem_in      = mem_in_q;
`ifdef RAM_BIST_FAIL_COUNT_EN
    assign fail_count      = fail_cnt_q;
`endif

endmodule

// File: tb/tb_ram_bist.sv
// Testbench for ram_bist with a 16-word behavioural RAM and stuck-at fault masks.
module tb_ram_bist;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
`ifdef RAM_BIST_FAIL_COUNT_EN
    logic [15:0]   fail_count;
`endif

    ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .BG(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
`ifdef RAM_BIST_FAIL_COUNT_EN
        .fail_count(fail_count),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] sa1 [NW];
    logic [DW-1:0] sa0 [NW];
    int            wr_cnt = 0;
    int            bad_in = 0;
    int            n_cmp  = 0;
    int            n_fail = 0;

    assign bus.mem_out = (mem[bus.mem_address] | sa1[bus.mem_address]) & ~sa0[bus.mem_address];

    // Behavioural RAM write port plus write-edge counter.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_rw) begin
            mem[bus.mem_address] <= bus.mem_in;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Write data must be zero during read cycles.
    always @(negedge clk) begin
        if (bus.mem_en && !bus.mem_rw && bus.mem_in != '0) bad_in <= bad_in + 1;
    end

    typedef struct {
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_sa1, a_sa0;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_sa1, b_sa0;
        int            restart_at;
        logic          exp_fail;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [15:0]   exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k);
        int cycles;
        int nz;
        for (int i = 0; i < NW; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
        sa1[vecs[k].a_addr] = sa1[vecs[k].a_addr] | vecs[k].a_sa1;
        sa0[vecs[k].a_addr] = sa0[vecs[k].a_addr] | vecs[k].a_sa0;
        sa1[vecs[k].b_addr] = sa1[vecs[k].b_addr] | vecs[k].b_sa1;
        sa0[vecs[k].b_addr] = sa0[vecs[k].b_addr] | vecs[k].b_sa0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d start_busy", k), 32'(busy), 32'd1);
        check($sformatf("v%0d start_done_clr", k), 32'(done), 32'd0);
        check($sformatf("v%0d start_fail_clr", k), {fail, 15'd0, fail_addr, fail_data}, 32'd0);
        cycles = 0;
        while (busy === 1'b1 && cycles < 400) begin
            cycles++;
            start = (cycles == vecs[k].restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("v%0d busy_cycles", k), 32'(cycles), 32'd160);
        check($sformatf("v%0d done", k), 32'(done), 32'd1);
        check($sformatf("v%0d mem_en_off", k), 32'(bus.mem_en), 32'd0);
        check($sformatf("v%0d fail", k), 32'(fail), 32'(vecs[k].exp_fail));
        check($sformatf("v%0d fail_addr", k), 32'(fail_addr), 32'(vecs[k].exp_addr));
        check($sformatf("v%0d fail_data", k), 32'(fail_data), 32'(vecs[k].exp_data));
`ifdef RAM_BIST_FAIL_COUNT_EN
        check($sformatf("v%0d fail_count", k), 32'(fail_count), 32'(vecs[k].exp_cnt));
`endif
        nz = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== 16'h0000) nz++;
        check($sformatf("v%0d mem_nonzero_words", k), 32'(nz), 32'd0);
        check($sformatf("v%0d mem_in_on_read", k), 32'(bad_in), 32'd0);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d done_held", k), {30'd0, busy, done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        //               a_addr sa1      sa0      b_addr sa1      sa0      rst  fail addr data      cnt
        vecs[0] = '{4'd0,  16'h0000, 16'h0000, 4'd0,  16'h0000, 16'h0000, 0,  1'b0, 4'd0,  16'h0000, 16'd0};
        vecs[1] = '{4'd5,  16'h0008, 16'h0000, 4'd5,  16'h0000, 16'h0000, 50, 1'b1, 4'd5,  16'h0008, 16'd3};
        vecs[2] = '{4'd5,  16'h0000, 16'h0008, 4'd5,  16'h0000, 16'h0000, 0,  1'b1, 4'd5,  16'hFFF7, 16'd2};
        vecs[3] = '{4'd5,  16'h0008, 16'h0000, 4'd9,  16'h0001, 16'h0000, 0,  1'b1, 4'd5,  16'h0008, 16'd6};
        vecs[4] = '{4'd2,  16'h0001, 16'h0000, 4'd1,  16'h0000, 16'h8000, 0,  1'b1, 4'd2,  16'h0001, 16'd5};
        vecs[5] = '{4'd15, 16'h0000, 16'h8000, 4'd15, 16'h0000, 16'h0000, 0,  1'b1, 4'd15, 16'h7FFF, 16'd2};
        for (int i = 0; i < NW; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end

        #12;
        check("rst_status", {28'd0, busy, done, fail, bus.mem_en}, 32'd0);
        check("rst_fail_addr", 32'(fail_addr), 32'd0);
        check("rst_fail_data", 32'(fail_data), 32'd0);
        check("rst_bus", {bus.mem_rw, 11'd0, bus.mem_address, bus.mem_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_busy", {30'd0, busy, done}, 32'd0);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Reset asserted at cycle 70 of a run.
        for (int i = 0; i < NW; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (69) @(negedge clk);
        check("mid_run_busy", {30'd0, busy, bus.mem_en}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        snap = wr_cnt;
        repeat (4) @(negedge clk);
        check("no_writes_in_reset", 32'(wr_cnt), 32'(snap));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {29'd0, busy, done, bus.mem_en}, 32'd0);
        check("post_rst_no_writes", 32'(wr_cnt), 32'(snap));

        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
